// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator control sequencer.
package calc_pkg;

    typedef enum logic [3:0] {
        START,
        OP_A,
        OP_A_NEG,
        OPRND,
        OP_B,
        OP_B_NEG,
        EXEC,
        RESULT,
        ERROR
    } state_t;

    localparam logic [1:0] DISP_A   = 2'b00;
    localparam logic [1:0] DISP_B   = 2'b01;
    localparam logic [1:0] DISP_RES = 2'b10;
    localparam logic [1:0] DISP_ERR = 2'b11;

endpackage

// File: rtl/calc_digit_counter.sv
// Saturating up/down digit counter shared by both operands; clear wins over load-full.
module calc_digit_counter #(
    parameter int unsigned MAX_DIGITS = 8,
    parameter int unsigned CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load_full,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_DIGITS);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load_full) begin
            count <= FULL;
        end else if (inc && (count != FULL)) begin
            count <= count + CNT_W'(1);
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: turns key strobes into datapath pulses, runs a
// handshaked ALU execute with timeout, chains results and holds an error state.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned MAX_DIGITS   = 8,
    parameter int unsigned CNT_W        = $clog2(MAX_DIGITS + 1),
    parameter int unsigned EXEC_TIMEOUT = 16,
    parameter bit          CHAIN_EN     = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             dig_in,
    input  logic             sub_in,
    input  logic             op_in,
    input  logic             ex_in,
    input  logic             bksp_in,
    input  logic             ms_in,
    input  logic             mr_in,
    input  logic             mc_in,
    input  logic             clear_in,
    input  logic             alu_done_in,
    input  logic             alu_err_in,
    output logic             load_a,
    output logic             load_b,
    output logic             bksp_a,
    output logic             bksp_b,
    output logic             load_a_mem,
    output logic             load_b_mem,
    output logic             load_a_res,
    output logic             load_mem,
    output logic             clear_mem,
    output logic             load_op,
    output logic             execute,
    output logic             reset_out,
    output logic [1:0]       display_select,
    output logic [CNT_W-1:0] digit_count,
    output logic             busy,
    output logic             error
);

    localparam int unsigned      T_W    = $clog2(EXEC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(MAX_DIGITS);
    localparam logic [T_W-1:0]   T_LAST = T_W'(EXEC_TIMEOUT - 1);

    state_t         state, state_n;
    logic           neg_a, neg_a_n, neg_b, neg_b_n;
    logic [T_W-1:0] tcnt, tcnt_n;
    logic           cnt_clr, cnt_full, cnt_inc, cnt_dec;
    logic           w_ex, w_op, w_mr, w_dig, w_sub, w_bksp;
    logic           mem_ok, room, last_digit;

    // One-hot winner of the strobe priority chain (clear handled separately).
    assign w_ex   = ex_in   & ~clear_in;
    assign w_op   = op_in   & ~(clear_in | ex_in);
    assign w_mr   = mr_in   & ~(clear_in | ex_in | op_in);
    assign w_dig  = dig_in  & ~(clear_in | ex_in | op_in | mr_in);
    assign w_sub  = sub_in  & ~(clear_in | ex_in | op_in | mr_in | dig_in);
    assign w_bksp = bksp_in & ~(clear_in | ex_in | op_in | mr_in | dig_in | sub_in);

    assign mem_ok     = (state != EXEC) && (state != ERROR);
    assign room       = digit_count < FULL;
    assign last_digit = digit_count <= CNT_W'(1);

    calc_digit_counter #(
        .MAX_DIGITS(MAX_DIGITS),
        .CNT_W     (CNT_W)
    ) u_digit_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr      (cnt_clr),
        .load_full(cnt_full),
        .inc      (cnt_inc),
        .dec      (cnt_dec),
        .count    (digit_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= START;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            tcnt  <= '0;
        end else begin
            state <= state_n;
            neg_a <= neg_a_n;
            neg_b <= neg_b_n;
            tcnt  <= tcnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        neg_a_n    = neg_a;
        neg_b_n    = neg_b;
        tcnt_n     = tcnt;
        cnt_clr    = 1'b0;
        cnt_full   = 1'b0;
        cnt_inc    = 1'b0;
        cnt_dec    = 1'b0;
        load_a     = 1'b0;
        load_b     = 1'b0;
        bksp_a     = 1'b0;
        bksp_b     = 1'b0;
        load_a_mem = 1'b0;
        load_b_mem = 1'b0;
        load_a_res = 1'b0;
        load_op    = 1'b0;
        execute    = 1'b0;
        reset_out  = 1'b0;
        load_mem   = ms_in & mem_ok;
        clear_mem  = mc_in & mem_ok;
        busy       = (state == EXEC);
        error      = (state == ERROR);

        case (state)
            START, OP_A, OP_A_NEG: display_select = DISP_A;
            OPRND, OP_B, OP_B_NEG: display_select = DISP_B;
            EXEC, RESULT:          display_select = DISP_RES;
            default:               display_select = DISP_ERR;
        endcase

        if (clear_in) begin
            reset_out = 1'b1;
            state_n   = START;
            cnt_clr   = 1'b1;
            neg_a_n   = 1'b0;
            neg_b_n   = 1'b0;
        end else begin
            case (state)
                START, OP_A_NEG: begin
                    if (w_dig) begin
                        load_a  = 1'b1;
                        cnt_inc = 1'b1;
                        state_n = OP_A;
                    end else if (w_mr) begin
                        load_a_mem = 1'b1;
                        cnt_full   = 1'b1;
                        state_n    = OP_A;
                    end else if (state == START) begin
                        if (w_sub) begin
                            load_a  = 1'b1;
                            neg_a_n = 1'b1;
                            state_n = OP_A_NEG;
                        end else begin
                            reset_out = 1'b1;
                        end
                    end else if (w_sub || w_bksp) begin
                        bksp_a  = 1'b1;
                        neg_a_n = 1'b0;
                        state_n = START;
                    end
                end
                OP_A: begin
                    if (w_op) begin
                        load_op = 1'b1;
                        cnt_clr = 1'b1;
                        state_n = OPRND;
                    end else if (w_mr) begin
                        load_a_mem = 1'b1;
                        cnt_full   = 1'b1;
                    end else if (w_dig) begin
                        load_a  = room;
                        cnt_inc = room;
                    end else if (w_bksp) begin
                        bksp_a  = 1'b1;
                        cnt_dec = 1'b1;
                        if (last_digit) state_n = neg_a ? OP_A_NEG : START;
                    end
                end
                OPRND, OP_B_NEG: begin
                    if (w_dig) begin
                        load_b  = 1'b1;
                        cnt_inc = 1'b1;
                        state_n = OP_B;
                    end else if (w_mr) begin
                        load_b_mem = 1'b1;
                        cnt_full   = 1'b1;
                        state_n    = OP_B;
                    end else if (state == OPRND) begin
                        if (w_sub) begin
                            load_b  = 1'b1;
                            neg_b_n = 1'b1;
                            state_n = OP_B_NEG;
                        end
                    end else if (w_sub || w_bksp) begin
                        bksp_b  = 1'b1;
                        neg_b_n = 1'b0;
                        state_n = OPRND;
                    end
                end
                OP_B: begin
                    if (w_ex) begin
                        execute = 1'b1;
                        tcnt_n  = '0;
                        state_n = EXEC;
                    end else if (w_mr) begin
                        load_b_mem = 1'b1;
                        cnt_full   = 1'b1;
                    end else if (w_dig) begin
                        load_b  = room;
                        cnt_inc = room;
                    end else if (w_bksp) begin
                        bksp_b  = 1'b1;
                        cnt_dec = 1'b1;
                        if (last_digit) state_n = neg_b ? OP_B_NEG : OPRND;
                    end
                end
                EXEC: begin
                    if (alu_done_in) begin
                        state_n = alu_err_in ? ERROR : RESULT;
                    end else if (tcnt == T_LAST) begin
                        state_n = ERROR;
                    end else begin
                        tcnt_n = tcnt + T_W'(1);
                    end
                end
                RESULT: begin
                    if (w_op && CHAIN_EN) begin
                        load_a_res = 1'b1;
                        load_op    = 1'b1;
                        neg_a_n    = 1'b0;
                        neg_b_n    = 1'b0;
                        cnt_clr    = 1'b1;
                        state_n    = OPRND;
                    end else if (w_dig) begin
                        reset_out = 1'b1;
                        neg_a_n   = 1'b0;
                        neg_b_n   = 1'b0;
                        cnt_clr   = 1'b1;
                        state_n   = START;
                    end
                end
                ERROR: ;
                default: state_n = START;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed scenarios plus random strobes
// compared each cycle against an operand-level behavioural model.
module tb_calc_sequencer;

    localparam int MAXD = 8;
    localparam int TMO  = 16;
    localparam int CW   = 4;

    localparam logic [10:0] K_NONE = 11'h000;
    localparam logic [10:0] K_DIG  = 11'h001;
    localparam logic [10:0] K_SUB  = 11'h002;
    localparam logic [10:0] K_OP   = 11'h004;
    localparam logic [10:0] K_EX   = 11'h008;
    localparam logic [10:0] K_BKSP = 11'h010;
    localparam logic [10:0] K_MS   = 11'h020;
    localparam logic [10:0] K_MR   = 11'h040;
    localparam logic [10:0] K_MC   = 11'h080;
    localparam logic [10:0] K_CLR  = 11'h100;
    localparam logic [10:0] K_DONE = 11'h200;
    localparam logic [10:0] K_AERR = 11'h400;

    localparam int M_ENTRY = 0;
    localparam int M_EXEC  = 1;
    localparam int M_RES   = 2;
    localparam int M_ERR   = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic dig_in = 1'b0, sub_in = 1'b0, op_in = 1'b0, ex_in = 1'b0, bksp_in = 1'b0;
    logic ms_in = 1'b0, mr_in = 1'b0, mc_in = 1'b0, clear_in = 1'b0;
    logic alu_done_in = 1'b0, alu_err_in = 1'b0;
    logic load_a, load_b, bksp_a, bksp_b, load_a_mem, load_b_mem, load_a_res;
    logic load_mem, clear_mem, load_op, execute, reset_out, busy, error;
    logic [1:0]    display_select;
    logic [CW-1:0] digit_count;

    int errors = 0;
    int checks = 0;

    logic [19:0] act, exp_v;

    // Model: which operand is being entered, how many digits it has, its sign,
    // and whether we are entering, executing, showing a result or in error.
    int m_mode, m_opnd, m_d, m_t;
    int n_mode, n_opnd, n_d, n_t;
    bit m_neg[2];
    bit n_neg[2];

    calc_sequencer #(
        .MAX_DIGITS  (MAXD),
        .CNT_W       (CW),
        .EXEC_TIMEOUT(TMO),
        .CHAIN_EN    (1'b1)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .dig_in        (dig_in),
        .sub_in        (sub_in),
        .op_in         (op_in),
        .ex_in         (ex_in),
        .bksp_in       (bksp_in),
        .ms_in         (ms_in),
        .mr_in         (mr_in),
        .mc_in         (mc_in),
        .clear_in      (clear_in),
        .alu_done_in   (alu_done_in),
        .alu_err_in    (alu_err_in),
        .load_a        (load_a),
        .load_b        (load_b),
        .bksp_a        (bksp_a),
        .bksp_b        (bksp_b),
        .load_a_mem    (load_a_mem),
        .load_b_mem    (load_b_mem),
        .load_a_res    (load_a_res),
        .load_mem      (load_mem),
        .clear_mem     (clear_mem),
        .load_op       (load_op),
        .execute       (execute),
        .reset_out     (reset_out),
        .display_select(display_select),
        .digit_count   (digit_count),
        .busy          (busy),
        .error         (error)
    );

    always #5 clock = ~clock;

    assign act = {load_a, load_b, bksp_a, bksp_b, load_a_mem, load_b_mem, load_a_res,
                  load_mem, clear_mem, load_op, execute, reset_out, busy, error,
                  display_select, digit_count};

    task automatic set_inputs(input logic [10:0] s);
        dig_in      = s[0];
        sub_in      = s[1];
        op_in       = s[2];
        ex_in       = s[3];
        bksp_in     = s[4];
        ms_in       = s[5];
        mr_in       = s[6];
        mc_in       = s[7];
        clear_in    = s[8];
        alu_done_in = s[9];
        alu_err_in  = s[10];
    endtask

    task automatic model_reset();
        m_mode   = M_ENTRY;
        m_opnd   = 0;
        m_d      = 0;
        m_t      = 0;
        m_neg[0] = 1'b0;
        m_neg[1] = 1'b0;
    endtask

    task automatic model_eval(input logic [10:0] s);
        logic la, lb, ba, bb, lam, lbm, lar, lm, cm, lo, ex, ro;
        logic [1:0] disp;
        int w;
        la = 0; lb = 0; ba = 0; bb = 0; lam = 0; lbm = 0; lar = 0;
        lo = 0; ex = 0; ro = 0;
        n_mode = m_mode; n_opnd = m_opnd; n_d = m_d; n_t = m_t; n_neg = m_neg;
        if (s[8])       w = 8;
        else if (s[3])  w = 7;
        else if (s[2])  w = 6;
        else if (s[6])  w = 5;
        else if (s[0])  w = 4;
        else if (s[1])  w = 3;
        else if (s[4])  w = 2;
        else            w = 0;
        lm = s[5] && (m_mode == M_ENTRY || m_mode == M_RES);
        cm = s[7] && (m_mode == M_ENTRY || m_mode == M_RES);
        if (w == 8) begin
            ro = 1; n_mode = M_ENTRY; n_opnd = 0; n_d = 0; n_neg[0] = 0; n_neg[1] = 0;
        end else if (m_mode == M_ENTRY) begin
            case (w)
                7: if (m_opnd == 1 && m_d > 0) begin ex = 1; n_mode = M_EXEC; n_t = 0; end
                6: if (m_opnd == 0 && m_d > 0) begin lo = 1; n_opnd = 1; n_d = 0; end
                5: begin
                    if (m_opnd == 0) lam = 1; else lbm = 1;
                    n_d = MAXD;
                end
                4: if (m_d < MAXD) begin
                    if (m_opnd == 0) la = 1; else lb = 1;
                    n_d = m_d + 1;
                end
                3: if (m_d == 0) begin
                    if (!m_neg[m_opnd]) begin
                        if (m_opnd == 0) la = 1; else lb = 1;
                    end else begin
                        if (m_opnd == 0) ba = 1; else bb = 1;
                    end
                    n_neg[m_opnd] = !m_neg[m_opnd];
                end
                2: if (m_d > 0 || m_neg[m_opnd]) begin
                    if (m_opnd == 0) ba = 1; else bb = 1;
                    if (m_d > 0) n_d = m_d - 1; else n_neg[m_opnd] = 0;
                end
                default: ;
            endcase
            if (m_opnd == 0 && m_d == 0 && !m_neg[0] && !(w == 3 || w == 4 || w == 5)) ro = 1;
        end else if (m_mode == M_EXEC) begin
            if (s[9])                n_mode = s[10] ? M_ERR : M_RES;
            else if (m_t + 1 >= TMO) n_mode = M_ERR;
            else                     n_t = m_t + 1;
        end else if (m_mode == M_RES) begin
            if (w == 6) begin
                lar = 1; lo = 1; n_mode = M_ENTRY; n_opnd = 1; n_d = 0;
                n_neg[0] = 0; n_neg[1] = 0;
            end else if (w == 4) begin
                ro = 1; n_mode = M_ENTRY; n_opnd = 0; n_d = 0;
                n_neg[0] = 0; n_neg[1] = 0;
            end
        end
        if (m_mode == M_ENTRY)    disp = (m_opnd == 1) ? 2'b01 : 2'b00;
        else if (m_mode == M_ERR) disp = 2'b11;
        else                      disp = 2'b10;
        exp_v = {la, lb, ba, bb, lam, lbm, lar, lm, cm, lo, ex, ro,
                 (m_mode == M_EXEC), (m_mode == M_ERR), disp, CW'(m_d)};
    endtask

    task automatic drive(input logic [10:0] s);
        @(negedge clock);
        set_inputs(s);
        #1;
        model_eval(s);
    endtask

    task automatic advance();
        @(posedge clock);
        m_mode = n_mode; m_opnd = n_opnd; m_d = n_d; m_t = n_t; m_neg = n_neg;
        #1;
        set_inputs(K_NONE);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_inputs(K_NONE);
        #3;
        checks++;
        if ({load_a, load_b, bksp_a, bksp_b, load_a_mem, load_b_mem, load_a_res,
             load_op, execute, busy, error, display_select, digit_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs act=%h required all-zero", act);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        drive(K_NONE);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL reset_idle act=%h exp=%h", act, exp_v);
        end
        advance();
    endtask

    task automatic test_basic();
        logic [10:0] seq[12] = '{K_CLR, K_DIG, K_DIG, K_DIG, K_OP, K_DIG, K_DIG, K_EX,
                                 K_NONE, K_NONE, K_NONE, K_DONE};
        int n_la = 0, n_lb = 0, n_lo = 0, n_ex = 0, n_busy = 0;
        foreach (seq[i]) begin
            drive(seq[i]);
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL basic cyc=%0d act=%h exp=%h", i, act, exp_v);
            end
            n_la += int'(load_a); n_lb += int'(load_b); n_lo += int'(load_op);
            n_ex += int'(execute); n_busy += int'(busy);
            advance();
        end
        drive(K_NONE);
        checks++;
        if ({n_la, n_lo, n_lb, n_ex, n_busy} !== {32'd3, 32'd1, 32'd2, 32'd1, 32'd4}) begin
            errors++;
            $display("FAIL basic_counts la=%0d op=%0d lb=%0d ex=%0d busy=%0d required 3 1 2 1 4",
                     n_la, n_lo, n_lb, n_ex, n_busy);
        end
        checks++;
        if (display_select !== 2'b10) begin
            errors++;
            $display("FAIL basic_result_disp act=%b required 10", display_select);
        end
        advance();
    endtask

    task automatic test_saturation();
        int n_la = 0;
        for (int i = 0; i < 11; i++) begin
            drive((i == 0) ? K_CLR : K_DIG);
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL sat cyc=%0d act=%h exp=%h", i, act, exp_v);
            end
            n_la += int'(load_a);
            advance();
        end
        drive(K_NONE);
        checks++;
        if (n_la != 8 || digit_count !== CW'(8)) begin
            errors++;
            $display("FAIL sat_limit loads=%0d count=%0d required 8 8", n_la, digit_count);
        end
        advance();
    endtask

    task automatic test_neg_bksp();
        logic [10:0] seq[7] = '{K_CLR, K_SUB, K_DIG, K_BKSP, K_BKSP, K_NONE, K_SUB};
        logic [2:0]  req[7] = '{3'b001, 3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b100};
        foreach (seq[i]) begin
            drive(seq[i]);
            checks++;
            if ({load_a, bksp_a, reset_out} !== req[i] || act !== exp_v) begin
                errors++;
                $display("FAIL neg_bksp cyc=%0d la/ba/ro=%b required %b act=%h exp=%h",
                         i, {load_a, bksp_a, reset_out}, req[i], act, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_timeout();
        int n_busy = 0;
        logic [10:0] s;
        for (int i = 0; i < 24; i++) begin
            if (i == 0 || i == 22)      s = K_CLR;
            else if (i == 1 || i == 3)  s = K_DIG;
            else if (i == 2)            s = K_OP;
            else if (i == 4)            s = K_EX;
            else if (i == 21)           s = K_DIG;
            else                        s = K_NONE;
            drive(s);
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL timeout cyc=%0d act=%h exp=%h", i, act, exp_v);
            end
            n_busy += int'(busy);
            if (i == 21) begin
                checks++;
                if ({error, display_select, load_a, load_b} !== 5'b11100) begin
                    errors++;
                    $display("FAIL timeout_error err/disp/la/lb=%b required 11100",
                             {error, display_select, load_a, load_b});
                end
            end
            if (i == 23) begin
                checks++;
                if ({error, display_select, reset_out} !== 4'b0001) begin
                    errors++;
                    $display("FAIL timeout_clear err/disp/ro=%b required 0001",
                             {error, display_select, reset_out});
                end
            end
            advance();
        end
        checks++;
        if (n_busy != TMO) begin
            errors++;
            $display("FAIL timeout_busy cycles=%0d required %0d", n_busy, TMO);
        end
    endtask

    task automatic test_chain();
        logic [10:0] seq[8] = '{K_CLR, K_DIG, K_OP, K_DIG, K_EX, K_DONE, K_OP, K_NONE};
        foreach (seq[i]) begin
            drive(seq[i]);
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL chain cyc=%0d act=%h exp=%h", i, act, exp_v);
            end
            if (i == 6) begin
                checks++;
                if ({load_a_res, load_op} !== 2'b11) begin
                    errors++;
                    $display("FAIL chain_pulses res/op=%b required 11", {load_a_res, load_op});
                end
            end
            if (i == 7) begin
                checks++;
                if (display_select !== 2'b01) begin
                    errors++;
                    $display("FAIL chain_disp act=%b required 01", display_select);
                end
            end
            advance();
        end
    endtask

    task automatic test_priority();
        logic [10:0] seq[6] = '{K_CLR, K_DIG, K_OP | K_DIG, K_EX | K_OP | K_DIG,
                                K_MR | K_DIG | K_SUB, K_BKSP | K_SUB};
        foreach (seq[i]) begin
            drive(seq[i]);
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL priority cyc=%0d act=%h exp=%h", i, act, exp_v);
            end
            if (i == 2) begin
                checks++;
                if ({load_op, load_a} !== 2'b10) begin
                    errors++;
                    $display("FAIL priority_op_dig op/la=%b required 10", {load_op, load_a});
                end
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] seq[6] = '{K_CLR, K_DIG, K_OP, K_DIG, K_EX, K_NONE};
        foreach (seq[i]) begin
            drive(seq[i]);
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL areset cyc=%0d act=%h exp=%h", i, act, exp_v);
            end
            if (i < 5) advance();
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, error, display_select, digit_count} !== '0) begin
            errors++;
            $display("FAIL areset_immediate busy/err/disp/cnt=%b required 0",
                     {busy, error, display_select, digit_count});
        end
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        drive(K_NONE);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL areset_after act=%h exp=%h", act, exp_v);
        end
        advance();
    endtask

    task automatic test_random();
        logic [10:0] s;
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < 11; b++) begin
                s[b] = ($urandom_range(0, (b == 8) ? 60 : 4) == 0);
            end
            drive(s);
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL random cyc=%0d stim=%h act=%h exp=%h", i, s, act, exp_v);
            end
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_saturation();
        test_neg_bksp();
        test_timeout();
        test_chain();
        test_priority();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Next-generation calculator control FSM, parametrised in operand length and ALU latency.
- Sequences key strobes into datapath load/backspace/memory/execute pulses. Adds per-operand digit counting, a handshaked multi-cycle ALU execute with timeout, result chaining and an error state.
- Sits between the keypad decoder and the operand/memory/ALU datapath; drives the display mux select.

Parameters:
- MAX_DIGITS, 8: maximum digits per operand; further dig_in is ignored.
- CNT_W, $clog2(MAX_DIGITS+1): digit counter width.
- EXEC_TIMEOUT, 16: cycles waited in EXEC for alu_done_in before entering ERROR.
- CHAIN_EN, 1: 1 = op_in in RESULT chains the result into operand A.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- dig_in, sub_in, op_in, ex_in, bksp_in  in  1 each  single-cycle key strobes.
- ms_in, mr_in, mc_in  in  1 each  memory store/recall/clear strobes.
- clear_in  in  1  soft clear strobe.
- alu_done_in  in  1  ALU finished; 1-cycle pulse.
- alu_err_in  in  1  ALU error, qualified by alu_done_in.
- load_a, load_b, bksp_a, bksp_b  out  1 each  operand digit load/remove pulses.
- load_a_mem, load_b_mem  out  1 each  copy memory into operand.
- load_a_res  out  1  copy result into operand A (chaining).
- load_mem, clear_mem, load_op, execute  out  1 each  pulses.
- reset_out  out  1  datapath clear.
- display_select  out  2  00=A, 01=B, 10=result, 11=error.
- digit_count  out  CNT_W  digits in the active operand.
- busy  out  1  high in EXEC.
- error  out  1  high in ERROR.

Behaviour:
- reset_n low (async): state=START, counter=0, neg flags=0, timeout counter=0. All pulse outputs 0, display_select=00, busy=0, error=0.
- Pulse outputs are combinational from state plus the strobe, in the same cycle; state and counters update on the next rising edge.
- Strobe priority when several arrive in one cycle: clear > ex > op > mr > dig > sub > bksp. Only the winner acts.
- ms_in/mc_in: load_mem/clear_mem follow the strobe in every state except EXEC and ERROR.
- clear_in in any state: reset_out=1; next state START; counter and neg flags cleared.
- START: reset_out=1 when idle.
  - dig -> load_a, count=1, OP_A.
  - mr -> load_a_mem, count=MAX_DIGITS, OP_A.
  - sub -> load_a, neg_a=1, OP_A_NEG.
- OP_A_NEG:
  - dig/mr -> as in START, then OP_A.
  - sub or bksp -> bksp_a, neg_a=0, START.
- OP_A:
  - dig -> load_a and count+1 if count<MAX_DIGITS; else no pulse.
  - bksp -> bksp_a, count-1. If count was 1, go to OP_A_NEG if neg_a else START.
  - mr -> load_a_mem, count=MAX_DIGITS.
  - op -> load_op, count=0, OPRND.
- OPRND, OP_B_NEG, OP_B: mirror START, OP_A_NEG and OP_A using the B outputs and neg_b.
  - Backspace out of an empty B returns to OPRND.
  - ex in OP_B -> execute, timeout counter=0, EXEC.
  - ex in OPRND or OP_B_NEG is ignored.
- EXEC: busy=1; all strobes except clear ignored; timeout counter increments each cycle.
  - alu_done & !alu_err -> RESULT.
  - alu_done & alu_err -> ERROR.
  - Counter reaching EXEC_TIMEOUT-1 without done -> ERROR.
- RESULT:
  - dig -> reset_out, START; the digit is consumed.
  - op with CHAIN_EN=1 -> load_a_res, load_op, neg flags cleared, count=0, OPRND.
  - op with CHAIN_EN=0 -> ignored.
- ERROR: error=1; everything except clear ignored.
- display_select: 00 in START/OP_A/OP_A_NEG, 01 in OPRND/OP_B/OP_B_NEG, 10 in EXEC/RESULT, 11 in ERROR.
- Counters saturate at both ends; no wrap-around.

Decomposition:
- Shared package calc_pkg: state enum (START, OP_A, OP_A_NEG, OPRND, OP_B, OP_B_NEG, EXEC, RESULT, ERROR) and display select constants DISP_A, DISP_B, DISP_RES, DISP_ERR.
- One sub-module, calc_digit_counter: saturating up/down counter with load-full and clear, CNT_W wide. A single instance is shared by both operands and cleared on each operand switch.

Test Plan:
- Reset, then dig x3, op, dig x2, ex, alu_done 4 cycles later -> load_a x3, load_op, load_b x2, execute. busy for 4 cycles, then RESULT with display_select=10.
- MAX_DIGITS=8: 10 dig strobes in OP_A -> exactly 8 load_a pulses; digit_count holds 8.
- sub, dig, bksp, bksp -> load_a, load_a, bksp_a to OP_A_NEG, bksp_a to START with neg_a=0.
- ex issued, no alu_done for 16 cycles -> ERROR at cycle 16, error=1, display 11. dig ignored; clear -> reset_out, START.
- RESULT then op with CHAIN_EN=1 -> load_a_res and load_op in the same cycle, next state OPRND, display 01.
- op and dig in the same cycle in OP_A -> only load_op. reset_n asserted mid-EXEC -> immediate START, busy=0.
